// File: rtl/conv_window_buf_if.sv
// Handshake bundle between the sliding-window generator and its neighbours.
// Pixel side: in_data/in_valid/in_ready. Window side: win_data/win_valid/win_ready, frame_done.
// Optional coordinates win_row/win_col exist only with CONV_WINDOW_BUF_COORD_EN defined.
interface conv_window_buf_if #(
  parameter int DATA_WIDTH = 32,
  parameter int D          = 1,
  parameter int S          = 5,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28
) ();
  logic [D*DATA_WIDTH-1:0]     in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic [D*S*S*DATA_WIDTH-1:0] win_data;
  logic                        win_valid;
  logic                        win_ready;
  logic                        frame_done;
`ifdef CONV_WINDOW_BUF_COORD_EN
  logic [$clog2(IMG_H)-1:0]    win_row;
  logic [$clog2(IMG_W)-1:0]    win_col;

  modport master (output in_data, in_valid, win_ready,
                  input  in_ready, win_data, win_valid, frame_done, win_row, win_col);
  modport slave  (input  in_data, in_valid, win_ready,
                  output in_ready, win_data, win_valid, frame_done, win_row, win_col);
`else
  modport master (output in_data, in_valid, win_ready,
                  input  in_ready, win_data, win_valid, frame_done);
  modport slave  (input  in_data, in_valid, win_ready,
                  output in_ready, win_data, win_valid, frame_done);
`endif
endinterface

// File: rtl/conv_window_buf.sv
// Sliding SxS (x D channel) window generator over a raster pixel stream, stride 1, no padding.
// Ports: clk, rst (async active-low), io (slave side of conv_window_buf_if); latency 1 from the
// accepted pixel to win_valid; in_ready = !win_valid || win_ready. Optional macro CONV_WINDOW_BUF_COORD_EN
// adds win_row/win_col (top-left coordinate of the presented window).
module conv_window_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int D          = 1,
  parameter int S          = 5,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28
) (
  input logic           clk,
  input logic           rst,
  conv_window_buf_if.slave io
);
  localparam int PW = D*DATA_WIDTH;
  localparam int NE = D*S*S;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W-1);
  localparam logic [CW-1:0] COL_WIN_FIRST = CW'(S-1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H-1);
  localparam logic [RW-1:0] ROW_FILL_LAST = RW'(S-2);

  typedef enum logic {FILL, RUN} state_t;
  state_t state, state_next;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  // line_buf[0] holds the oldest buffered row, line_buf[S-2] the row just above the current one.
  logic [PW-1:0] line_buf [S-1][IMG_W];
  logic [PW-1:0] win_reg  [S][S];
  logic [PW-1:0] win_next [S][S];
  logic [NE*DATA_WIDTH-1:0] win_flat;
  logic [NE*DATA_WIDTH-1:0] win_data_q;
  logic win_valid_q, frame_done_q;
  logic accept, row_end, frame_end, emit;

  assign io.in_ready   = !win_valid_q || io.win_ready;
  assign io.win_valid  = win_valid_q;
  assign io.win_data   = win_data_q;
  assign io.frame_done = frame_done_q;

  assign accept    = io.in_valid && io.in_ready;
  assign row_end   = (col == COL_LAST);
  assign frame_end = row_end && (row == ROW_LAST);
  // Columns left of S-1 still hold the previous row's pixels, so no window there.
  assign emit      = accept && (state == RUN) && (col >= COL_WIN_FIRST);

  // Window after this pixel: shift left, append {line buffers oldest..newest, in_data}.
  always_comb begin
    win_next = win_reg;
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S-1; c++)
        win_next[r][c] = win_reg[r][c+1];
    for (int r = 0; r < S-1; r++)
      win_next[r][S-1] = line_buf[r][col];
    win_next[S-1][S-1] = io.in_data;
  end

  // Flatten to element i = d*S*S + r*S + c, element 0 in the most significant slice.
  always_comb begin
    win_flat = '0;
    for (int d = 0; d < D; d++)
      for (int r = 0; r < S; r++)
        for (int c = 0; c < S; c++)
          win_flat[(NE-1-(d*S*S + r*S + c))*DATA_WIDTH +: DATA_WIDTH] =
            win_next[r][c][(D-1-d)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Pixel storage is never cleared: every slot is rewritten before it contributes to a window.
  always_ff @(posedge clk) begin
    if (accept) begin
      win_reg <= win_next;
      for (int k = 0; k < S-2; k++)
        line_buf[k][col] <= line_buf[k+1][col];
      line_buf[S-2][col] <= io.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FILL;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL: if (accept && row_end && row == ROW_FILL_LAST) state_next = RUN;
      RUN:  if (accept && frame_end)                       state_next = FILL;
      default:                                             state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row          <= '0;
      col          <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_data_q   <= '0;
    end else begin
      frame_done_q <= accept && frame_end;
      if (accept) begin
        if (row_end) begin
          col <= '0;
          row <= frame_end ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      // A new window wins over a consume in the same cycle, keeping win_valid high.
      if (emit) begin
        win_valid_q <= 1'b1;
        win_data_q  <= win_flat;
      end else if (io.win_ready) begin
        win_valid_q <= 1'b0;
      end
    end
  end

`ifdef CONV_WINDOW_BUF_COORD_EN
  logic [RW-1:0] win_row_q;
  logic [CW-1:0] win_col_q;
  assign io.win_row = win_row_q;
  assign io.win_col = win_col_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_row_q <= '0;
      win_col_q <= '0;
    end else if (emit) begin
      win_row_q <= row - RW'(S-1);
      win_col_q <= col - CW'(S-1);
    end
  end
`endif
endmodule

// File: doc/conv_window_buf.md
Name: conv_window_buf

Overview:
- Streaming sliding-window generator that sits directly upstream of the convolution unit.
- Accepts one image pixel per beat, D channels packed per beat, in raster order.
- Keeps S-1 line buffers plus an SxS window register.
- Presents each complete D*S*S window (stride 1, no padding) in the exact flattened layout the convolution unit consumes as its img operand, with valid/ready flow control because the conv unit needs D*S*S cycles per window.

Parameters:
- DATA_WIDTH, 32, width of one element (channel sample).
- D, 1, channels per pixel / filter depth.
- S, 5, window (filter) size; S >= 2.
- IMG_W, 28, image width in pixels; IMG_W >= S.
- IMG_H, 28, image height in pixels; IMG_H >= S.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  D*DATA_WIDTH  one pixel; channel 0 in the most-significant DATA_WIDTH bits.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a pixel this cycle.
- win_data  out  D*S*S*DATA_WIDTH  window; element i = d*S*S + r*S + c (d channel, r row 0 = oldest, c col 0 = leftmost) in the i-th DATA_WIDTH slice counted from the MSB, so element 0 is most significant.
- win_valid  out  1  win_data holds an unconsumed window.
- win_ready  in  1  downstream takes the window.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (rst=0, async):
  - Outputs: win_valid=0, frame_done=0, win_data=0.
  - Counters: row=0, col=0.
  - FSM goes to FILL.
  - Line-buffer contents are not cleared; they are refilled before use.
- Handshake:
  - A pixel is accepted on a cycle with in_valid && in_ready.
  - in_ready = !win_valid || win_ready.
  - A window is consumed on a cycle with win_valid && win_ready.
  - win_data is stable while win_valid=1 && win_ready=0.
- On each accepted pixel:
  - Shift the line buffers and the window left by one column.
  - The new rightmost column is {line buffers (oldest..newest), in_data}.
  - Advance col; when col wraps at IMG_W-1, reset col to 0 and increment row.
- Window emission:
  - Emit when the accepted pixel has row >= S-1 and col >= S-1.
  - win_data and win_valid are registered; win_valid rises on the cycle after that acceptance (latency 1).
- Simultaneous consume and new window in the same cycle: win_data loads the new window and win_valid stays 1.
- Consume with no new window: win_valid falls the next cycle.
- Windows per frame: (IMG_W-S+1)*(IMG_H-S+1).
- No window is formed across a row boundary: col < S-1 produces no window, even though the window register holds stale columns.
- FSM states:
  - FILL: row < S-1. Goes to RUN on acceptance of the last pixel of row S-2.
  - RUN: emitting windows.
  - On acceptance of pixel (IMG_H-1, IMG_W-1): the final window is emitted, row and col return to 0, frame_done pulses next cycle, and the FSM goes to FILL.
  - The next frame may start on the following cycle.
- in_valid=0 causes no state change, and no bubble is required between frames.
- Reset mid-frame discards any partial frame and any pending window; the next accepted pixel is treated as (0,0).
- Line buffers: S-1 buffers of IMG_W-S... depth IMG_W each (register or inferred RAM), addressed by col.

Optional Feature:
- Macro CONV_WINDOW_BUF_COORD_EN.
- When defined, adds two outputs:
  - win_row (width $clog2(IMG_H)): top-left row of the window.
  - win_col (width $clog2(IMG_W)): top-left column of the window.
- Both are registered together with win_data, held under backpressure, and reset to 0.
- When not defined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Basic 3x3 window, first output (DATA_WIDTH=8, D=1, S=3, IMG_W=IMG_H=4): stream pixels 0..15 with win_ready=1 → first win_valid the cycle after pixel 10 is accepted, win_data = 0,1,2,4,5,6,8,9,10 (MSB first).
- Same stream, full frame → exactly 4 windows. The last window is 5,6,7,9,10,11,13,14,15, and frame_done pulses once, the cycle after pixel 15 is accepted.
- Backpressure: hold win_ready=0 when the first window appears → in_ready=0 and win_data stays 0,1,2,4,5,6,8,9,10. Release win_ready → the window is consumed, the remaining 3 windows arrive in order, and no pixel is lost.
- Two channels (D=2): pixel p = {p, p+100} → window element 0 = 0, element 9 = 100, element 17 = 110.
- Reset mid-frame: rst=0 after pixel 7, then restream pixels 0..15 → no window before pixel 10, 4 correct windows, and win_valid=0 during reset.
- CONV_WINDOW_BUF_COORD_EN defined → the windows report (win_row, win_col) as (0,0), (0,1), (1,0), (1,1) in order.
